// File: rtl/seven_seg_digit_driver_if.sv
// Signal bundle between a seven-segment scan source and the digit driver.
//
// master : produces digit_sel_i, value_i, dp_i, load_i, blank_lz_i and
//          observes the display drive and status outputs.
// slave  : the digit driver itself.
//
// Handshake semantics: there is no back-pressure on this bundle. load_i is a
// one-cycle strobe that is always accepted on the clock edge where it is high
// (a later strobe before the frame-start swap overwrites the earlier one).
// pending_o is a level that stays high from an accepted load until the swap;
// update_o is a single-cycle pulse on the swap edge. digit_sel_i is sampled
// every edge and needs no qualifier.
interface seven_seg_digit_driver_if;
  logic [2:0]  digit_sel_i;
  logic [15:0] value_i;
  logic [3:0]  dp_i;
  logic        load_i;
  logic        blank_lz_i;
  logic [3:0]  an_o;
  logic [6:0]  seg_o;
  logic        dp_o;
  logic        pending_o;
  logic        update_o;

  modport master (
    output digit_sel_i, value_i, dp_i, load_i, blank_lz_i,
    input  an_o, seg_o, dp_o, pending_o, update_o
  );

  modport slave (
    input  digit_sel_i, value_i, dp_i, load_i, blank_lz_i,
    output an_o, seg_o, dp_o, pending_o, update_o
  );
endinterface

// File: rtl/seven_seg_digit_driver.sv
// Digit driver for a 4-digit common-anode seven-segment display.
//
// Takes the scan code from the scan sequencer and a double-buffered 16-bit
// hex value, and produces registered active-low anode, segment and decimal
// point drive. Every digit change is followed by DEAD_CYCLES of dark anodes
// to suppress ghosting. Loaded values wait in a pending buffer and move to
// the displayed (shadow) buffer only when the scan returns to digit 0.
//
// Ports:
//   clk_i   - system clock, rising edge
//   reset_n - asynchronous active-low reset
//   port    - slave side of seven_seg_digit_driver_if (scan code, value,
//             dp, load strobe, leading-zero blank in; an/seg/dp drive,
//             pending level and update pulse out)
module seven_seg_digit_driver #(
  parameter int unsigned DEAD_CYCLES = 4,
  parameter int unsigned DEAD_W      = 8
) (
  input  logic                    clk_i,
  input  logic                    reset_n,
  seven_seg_digit_driver_if.slave port
);

  logic [2:0]        sel_q;
  logic [DEAD_W-1:0] dead_cnt;
  logic [15:0]       shadow_val, pend_val;
  logic [3:0]        shadow_dp, pend_dp;
  logic              pending_q, update_q;
  logic [3:0]        an_q;
  logic [6:0]        seg_q;
  logic              dp_q;

  logic              changed, swap, legal, blanked, lit;
  logic              zero1, zero2, zero3;
  logic [2:0]        sel_next;
  logic [DEAD_W-1:0] dead_next;
  logic [15:0]       sh_val_next;
  logic [3:0]        sh_dp_next;
  logic [1:0]        idx;
  logic [3:0]        nib;
  logic [3:0]        an_next;
  logic [6:0]        seg_next;
  logic              dp_next;

  function automatic logic [6:0] hex7(input logic [3:0] n);
    case (n)
      4'h0: hex7 = 7'b1000000;
      4'h1: hex7 = 7'b1111001;
      4'h2: hex7 = 7'b0100100;
      4'h3: hex7 = 7'b0110000;
      4'h4: hex7 = 7'b0011001;
      4'h5: hex7 = 7'b0010010;
      4'h6: hex7 = 7'b0000010;
      4'h7: hex7 = 7'b1111000;
      4'h8: hex7 = 7'b0000000;
      4'h9: hex7 = 7'b0010000;
      4'hA: hex7 = 7'b0001000;
      4'hB: hex7 = 7'b0000011;
      4'hC: hex7 = 7'b1000110;
      4'hD: hex7 = 7'b0100001;
      4'hE: hex7 = 7'b0000110;
      default: hex7 = 7'b0001110;
    endcase
  endfunction

  // All output registers are loaded from the post-edge view of the state,
  // so the pattern emitted on a capture edge already reflects the new digit
  // and, on a frame-start swap, the new shadow value.
  always_comb begin
    changed   = (port.digit_sel_i != sel_q);
    sel_next  = changed ? port.digit_sel_i : sel_q;
    dead_next = dead_cnt;
    if (changed)
      dead_next = DEAD_W'(DEAD_CYCLES);
    else if (dead_cnt != '0)
      dead_next = dead_cnt - DEAD_W'(1);

    swap        = changed && (port.digit_sel_i == 3'b000) && pending_q;
    sh_val_next = swap ? pend_val : shadow_val;
    sh_dp_next  = swap ? pend_dp  : shadow_dp;

    legal = 1'b1;
    idx   = 2'd0;
    case (sel_next)
      3'b000:  idx = 2'd0;
      3'b001:  idx = 2'd1;
      3'b011:  idx = 2'd2;
      3'b100:  idx = 2'd3;
      default: legal = 1'b0;
    endcase

    case (idx)
      2'd0:    nib = sh_val_next[3:0];
      2'd1:    nib = sh_val_next[7:4];
      2'd2:    nib = sh_val_next[11:8];
      default: nib = sh_val_next[15:12];
    endcase

    // Digit k is a leading zero when it and every more significant nibble
    // are zero; digit 0 always shows.
    zero3 = (sh_val_next[15:12] == 4'h0);
    zero2 = zero3 && (sh_val_next[11:8] == 4'h0);
    zero1 = zero2 && (sh_val_next[7:4] == 4'h0);
    case (idx)
      2'd1:    blanked = port.blank_lz_i && zero1;
      2'd2:    blanked = port.blank_lz_i && zero2;
      2'd3:    blanked = port.blank_lz_i && zero3;
      default: blanked = 1'b0;
    endcase

    lit      = legal && !blanked;
    an_next  = (lit && (dead_next == '0)) ? ~(4'b0001 << idx) : 4'b1111;
    seg_next = lit ? hex7(nib) : 7'b1111111;
    dp_next  = lit ? ~sh_dp_next[idx] : 1'b1;
  end

  always_ff @(posedge clk_i or negedge reset_n) begin
    if (!reset_n) begin
      sel_q      <= 3'b111;
      dead_cnt   <= '0;
      shadow_val <= '0;
      shadow_dp  <= '0;
      pend_val   <= '0;
      pend_dp    <= '0;
      pending_q  <= 1'b0;
      update_q   <= 1'b0;
      an_q       <= 4'b1111;
      seg_q      <= 7'b1111111;
      dp_q       <= 1'b1;
    end else begin
      sel_q      <= sel_next;
      dead_cnt   <= dead_next;
      shadow_val <= sh_val_next;
      shadow_dp  <= sh_dp_next;
      // The swap reads pend_val before this edge, so a load on the swap
      // edge stays pending for the next frame.
      if (port.load_i) begin
        pend_val <= port.value_i;
        pend_dp  <= port.dp_i;
      end
      pending_q <= port.load_i || (pending_q && !swap);
      update_q  <= swap;
      an_q      <= an_next;
      seg_q     <= seg_next;
      dp_q      <= dp_next;
    end
  end

  assign port.an_o      = an_q;
  assign port.seg_o     = seg_q;
  assign port.dp_o      = dp_q;
  assign port.pending_o = pending_q;
  assign port.update_o  = update_q;

endmodule

// File: tb/tb_seven_seg_digit_driver.sv
// Testbench for seven_seg_digit_driver: two instances (no dead time and
// four dead cycles) share one stimulus stream. A reference model at each
// rising edge pushes the expected outputs of both instances into exp_q; a
// monitor on the falling edge pops and compares.
module tb_seven_seg_digit_driver;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [2:0]  sel;
  logic [15:0] value;
  logic [3:0]  dp;
  logic        load;
  logic        blz;

  seven_seg_digit_driver_if if0 ();
  seven_seg_digit_driver_if if4 ();

  assign if0.digit_sel_i = sel;
  assign if0.value_i     = value;
  assign if0.dp_i        = dp;
  assign if0.load_i      = load;
  assign if0.blank_lz_i  = blz;
  assign if4.digit_sel_i = sel;
  assign if4.value_i     = value;
  assign if4.dp_i        = dp;
  assign if4.load_i      = load;
  assign if4.blank_lz_i  = blz;

  seven_seg_digit_driver #(.DEAD_CYCLES(0), .DEAD_W(8)) dut0 (
    .clk_i(clk), .reset_n(rst_n), .port(if0.slave));
  seven_seg_digit_driver #(.DEAD_CYCLES(4), .DEAD_W(8)) dut4 (
    .clk_i(clk), .reset_n(rst_n), .port(if4.slave));

  // ---------------- reference model ----------------
  // Per instance: {an[3:0], seg[6:0], dp, pending, update} = 14 bits.
  localparam logic [13:0] RST_OUT = {4'b1111, 7'b1111111, 1'b1, 1'b0, 1'b0};

  logic [27:0] exp_q[$];
  int          vectors = 0;
  int          miscompares = 0;

  logic [6:0]  hex_tab [16];
  logic [2:0]  m_sel;
  int          m_since;
  logic [15:0] m_sh_v, m_p_v;
  logic [3:0]  m_sh_dp, m_p_dp;
  logic        m_pend;

  initial hex_tab = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                      7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                      7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                      7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};

  function automatic int digit_of(input logic [2:0] c);
    case (c)
      3'b000:  return 0;
      3'b001:  return 1;
      3'b011:  return 2;
      3'b100:  return 3;
      default: return -1;
    endcase
  endfunction

  // Expected drive for an instance with 'dead' blanking cycles: the digit
  // lights once at least 'dead' edges have passed since the capture edge.
  function automatic logic [13:0] expect_out(input int dead, input int k,
                                             input logic upd);
    logic [3:0] an;
    logic [6:0] seg;
    logic       d;
    logic [3:0] nib;
    an  = 4'b1111;
    seg = 7'b1111111;
    d   = 1'b1;
    if (k >= 0 && !(blz && k > 0 && (m_sh_v >> (4 * k)) == 16'h0)) begin
      nib = m_sh_v[4*k +: 4];
      seg = hex_tab[nib];
      d   = ~m_sh_dp[k];
      if (m_since >= dead) an = ~(4'b0001 << k);
    end
    return {an, seg, d, m_pend, upd};
  endfunction

  always @(posedge clk) begin
    int   k;
    logic changed, upd;
    if (!rst_n) begin
      m_sel = 3'b111; m_since = 1000;
      m_sh_v = '0; m_sh_dp = '0; m_p_v = '0; m_p_dp = '0; m_pend = 1'b0;
      exp_q.push_back({RST_OUT, RST_OUT});
    end else begin
      k       = digit_of(sel);
      changed = (sel != m_sel);
      upd     = changed && (sel == 3'b000) && m_pend;
      if (upd) begin
        m_sh_v = m_p_v; m_sh_dp = m_p_dp; m_pend = 1'b0;
      end
      if (load) begin
        m_p_v = value; m_p_dp = dp; m_pend = 1'b1;
      end
      if (changed) begin
        m_sel = sel; m_since = 0;
      end else if (m_since < 1000) begin
        m_since = m_since + 1;
      end
      exp_q.push_back({expect_out(0, k, upd), expect_out(4, k, upd)});
    end
  end

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    logic [27:0] e, a;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      a = {if0.an_o, if0.seg_o, if0.dp_o, if0.pending_o, if0.update_o,
           if4.an_o, if4.seg_o, if4.dp_o, if4.pending_o, if4.update_o};
      vectors++;
      if (a !== e) begin
        miscompares++;
        $display("FAIL scoreboard t=%0t act=%07h req=%07h (dead0 | dead4: an,seg,dp,pend,upd)",
                 $time, a, e);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic hold(input logic [2:0] c, input int n);
    sel  = c;
    load = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_load(input logic [15:0] v, input logic [3:0] d);
    value = v;
    dp    = d;
    load  = 1'b1;
    @(negedge clk);
    load  = 1'b0;
  endtask

  task automatic frame(input int n);
    hold(3'b000, n); hold(3'b001, n); hold(3'b011, n); hold(3'b100, n);
  endtask

  task automatic check_reset_now();
    logic [27:0] a;
    a = {if0.an_o, if0.seg_o, if0.dp_o, if0.pending_o, if0.update_o,
         if4.an_o, if4.seg_o, if4.dp_o, if4.pending_o, if4.update_o};
    vectors++;
    if (a !== {RST_OUT, RST_OUT}) begin
      miscompares++;
      $display("FAIL reset_immediate act=%07h req=%07h", a, {RST_OUT, RST_OUT});
    end
  endtask

  // ---------------- stimulus ----------------
  logic [2:0] legal_codes [4];
  logic [2:0] illegal_codes [4];

  initial begin
    legal_codes   = '{3'b000, 3'b001, 3'b011, 3'b100};
    illegal_codes = '{3'b010, 3'b101, 3'b110, 3'b111};
    sel = 3'b100; value = '0; dp = '0; load = 1'b0; blz = 1'b0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Basic frame with 1A5F, no blanking.
    hold(3'b100, 2);
    pulse_load(16'h1A5F, 4'b0000);
    frame(8);

    // Dead time and a restart partway through it.
    hold(3'b000, 8);
    hold(3'b001, 3);
    hold(3'b011, 8);

    // Leading-zero blanking.
    blz = 1'b1;
    pulse_load(16'h0007, 4'b1111);
    hold(3'b100, 6);
    frame(6);
    pulse_load(16'h0000, 4'b0000);
    frame(6);
    hold(3'b000, 4);

    // Last load wins before frame start.
    blz = 1'b0;
    hold(3'b011, 2);
    pulse_load(16'h1234, 4'b0010);
    hold(3'b011, 2);
    hold(3'b100, 3);
    pulse_load(16'h5678, 4'b0100);
    hold(3'b100, 2);
    frame(5);

    // Load on the same edge as the swap.
    pulse_load(16'h9ABC, 4'b1000);
    sel = 3'b000;
    pulse_load(16'hDEF0, 4'b0001);
    hold(3'b000, 3);
    hold(3'b001, 3); hold(3'b011, 3); hold(3'b100, 3);
    frame(3);

    // Illegal code, then reset in the middle of a dead window.
    hold(3'b010, 5);
    hold(3'b011, 6);
    pulse_load(16'h4321, 4'b1111);
    hold(3'b001, 2);
    #2 rst_n = 1'b0;
    #1 check_reset_now();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    frame(5);

    // Randomized scan with loads and blanking.
    for (int it = 0; it < 60; it++) begin
      int r;
      int n;
      r   = $urandom_range(0, 9);
      sel = (r < 8) ? legal_codes[r % 4] : illegal_codes[r % 4];
      blz = 1'($urandom_range(0, 1));
      n   = $urandom_range(1, 8);
      for (int c = 0; c < n; c++) begin
        load = ($urandom_range(0, 4) == 0);
        value = ($urandom_range(0, 2) == 0) ? 16'($urandom_range(0, 255))
                                            : 16'($urandom);
        dp = 4'($urandom_range(0, 15));
        @(negedge clk);
      end
      load = 1'b0;
    end

    hold(3'b000, 3);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
